// File: rtl/mem_wait_unit_if.sv
// Bus between the EXE/MEM register side of the pipeline and mem_wait_unit.
// master: pipeline side, drives the *_input signals and store data.
// slave : mem_wait_unit, drives ready, gated enables, pass-throughs and load data.
interface mem_wait_unit_if;
  logic        mem_r_en_input;
  logic        mem_w_en_input;
  logic        wb_en_input;
  logic [3:0]  dest_input;
  logic [31:0] alu_res_input;
  logic [31:0] val_rm_i;

  logic        ready;
  logic        wb_en_output;
  logic        mem_r_en_output;
  logic [3:0]  dest_output;
  logic [31:0] alu_res_output;
  logic [31:0] data_mem_output;

  modport master (
    output mem_r_en_input, mem_w_en_input, wb_en_input, dest_input,
           alu_res_input, val_rm_i,
    input  ready, wb_en_output, mem_r_en_output, dest_output,
           alu_res_output, data_mem_output
  );

  modport slave (
    input  mem_r_en_input, mem_w_en_input, wb_en_input, dest_input,
           alu_res_input, val_rm_i,
    output ready, wb_en_output, mem_r_en_output, dest_output,
           alu_res_output, data_mem_output
  );
endinterface

// File: rtl/mem_wait_unit.sv
// mem_wait_unit: memory stage with a slow word-addressed SRAM model.
// Every load/store takes WAIT_STATES stall cycles (ready = 0) followed by one
// DONE cycle (ready = 1). Write-back and read enables are gated by ready so
// the MEM/WB register captures bubbles while the pipeline is frozen.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_wait_unit_if.slave: request inputs, ready, gated enables,
//          dest/alu pass-through, registered load data
// Optional: define MEM_WRITE_BUFFER_EN to compile in a one-entry posted
// write buffer that accepts stores without stalling and drains them after
// WAIT_STATES + 1 cycles.
module mem_wait_unit #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 5,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic            clk,
  input  logic            rst,
  mem_wait_unit_if.slave  bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [3:0]  LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [31:0] mem_q [DEPTH];

  logic          req, is_store;
  logic [AW-1:0] idx;
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;
  logic          post;       // store accepted straight into the write buffer
  logic          ready;

  assign req      = bus.mem_r_en_input | bus.mem_w_en_input;
  assign is_store = bus.mem_w_en_input;   // both bits set behaves as a store
  // Wraps on the low index bits; byte offset bits [1:0] are dropped.
  assign idx      = AW'((bus.alu_res_input - 32'(BASE_ADDR)) >> 2);

`ifdef MEM_WRITE_BUFFER_EN
  logic          wbuf_busy_q, wbuf_busy_d;
  logic [3:0]    wbuf_cnt_q, wbuf_cnt_d;
  logic [AW-1:0] wbuf_idx_q, wbuf_idx_d;
  logic [31:0]   wbuf_data_q, wbuf_data_d;
  logic          drain;

  assign post  = (state_q == IDLE) & is_store & ~wbuf_busy_q;
  // Counter starts at 1 on the accept edge, so the drain edge is the one
  // that ends cycle WAIT_STATES, matching the unbuffered store commit.
  assign drain = wbuf_busy_q & (wbuf_cnt_q == 4'(WAIT_STATES));
`else
  assign post  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef MEM_WRITE_BUFFER_EN
      wbuf_busy_q <= 1'b0;
      wbuf_cnt_q  <= '0;
      wbuf_idx_q  <= '0;
      wbuf_data_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef MEM_WRITE_BUFFER_EN
      wbuf_busy_q <= wbuf_busy_d;
      wbuf_cnt_q  <= wbuf_cnt_d;
      wbuf_idx_q  <= wbuf_idx_d;
      wbuf_data_q <= wbuf_data_d;
`endif
    end
  end

  // Array is not cleared by reset; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    mem_we    = 1'b0;
    mem_widx  = idx;
    mem_wdata = bus.val_rm_i;
    unique case (state_q)
      IDLE: begin
        // ready (computed below) is 0 here exactly when the FSM may start
        // or when the request is held off by a busy write buffer.
        if (req && !post && ready == 1'b0 && !(state_q != IDLE)) begin
`ifdef MEM_WRITE_BUFFER_EN
          if (!wbuf_busy_q) begin
`else
          begin
`endif
            cnt_d = 4'd1;
            if (WAIT_STATES == 1) begin
              state_d = DONE;
              if (!is_store) data_d = mem_q[idx];
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          if (!is_store) data_d = mem_q[idx];
        end
      end
      DONE: begin
        if (is_store) mem_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef MEM_WRITE_BUFFER_EN
    wbuf_busy_d = wbuf_busy_q;
    wbuf_cnt_d  = wbuf_cnt_q;
    wbuf_idx_d  = wbuf_idx_q;
    wbuf_data_d = wbuf_data_q;
    if (wbuf_busy_q) begin
      wbuf_cnt_d = wbuf_cnt_q + 4'd1;
      if (drain) wbuf_busy_d = 1'b0;
    end
    if (post) begin
      wbuf_busy_d = 1'b1;
      wbuf_cnt_d  = 4'd1;
      wbuf_idx_d  = idx;
      wbuf_data_d = bus.val_rm_i;
    end
    if (drain) begin
      mem_we    = 1'b1;
      mem_widx  = wbuf_idx_q;
      mem_wdata = wbuf_data_q;
    end
`endif
  end

  // Output logic
  always_comb begin
    ready = 1'b1;
    unique case (state_q)
      IDLE:    ready = ~req | post;
      WAIT:    ready = 1'b0;
      DONE:    ready = 1'b1;
      default: ready = 1'b1;
    endcase
    bus.ready           = ready;
    bus.wb_en_output    = bus.wb_en_input & ready;
    bus.mem_r_en_output = bus.mem_r_en_input & ready;
    bus.dest_output     = bus.dest_input;
    bus.alu_res_output  = bus.alu_res_input;
    bus.data_mem_output = data_q;
  end
endmodule

// File: tb/tb_mem_wait_unit.sv
module tb_mem_wait_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wait_unit_if a();
  mem_wait_unit_if b();

  mem_wait_unit #(.DEPTH(64), .WAIT_STATES(5), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .bus(a)
  );
  mem_wait_unit #(.DEPTH(64), .WAIT_STATES(1), .BASE_ADDR(1024)) dut1 (
    .clk(clk), .rst(rst), .bus(b)
  );

`ifdef MEM_WRITE_BUFFER_EN
  localparam int ST_STALL    = 0;
  localparam int LD_AFTER_ST = 10;
`else
  localparam int ST_STALL    = 5;
  localparam int LD_AFTER_ST = 5;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic idle_inputs();
    a.mem_r_en_input = 0; a.mem_w_en_input = 0; a.wb_en_input = 0;
    a.dest_input = '0; a.alu_res_input = '0; a.val_rm_i = '0;
    b.mem_r_en_input = 0; b.mem_w_en_input = 0; b.wb_en_input = 0;
    b.dest_input = '0; b.alu_res_input = '0; b.val_rm_i = '0;
  endtask

  // Drives one memory instruction on bus a (called at posedge+1) and holds it
  // until ready; load data seen in the completing cycle goes to got_q.
  task automatic run_op(input bit ld, input bit st, input logic [31:0] addr,
                        input logic [31:0] data, output int stalls,
                        output int wbp, output bit to);
    a.mem_r_en_input = ld; a.mem_w_en_input = st; a.wb_en_input = ld;
    a.dest_input = 4'd3; a.alu_res_input = addr; a.val_rm_i = data;
    stalls = 0; wbp = 0; to = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (a.wb_en_output) wbp++;
      if (a.ready) begin
        if (ld && !st) got_q.push_back(a.data_mem_output);
        to = 0;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      if (!to) break;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    n_cmp++; if (a.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", a.ready); end
    n_cmp++; if (a.data_mem_output !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h exp 0", a.data_mem_output); end
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    a.wb_en_input = 1; a.dest_input = 4'd5; a.alu_res_input = 32'h0000_1234;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (a.ready !== 1'b1) begin n_bad++; $display("FAIL nomem_ready cyc %0d got %b exp 1", c, a.ready); end
      n_cmp++; if (a.wb_en_output !== 1'b1) begin n_bad++; $display("FAIL nomem_wb cyc %0d got %b exp 1", c, a.wb_en_output); end
      n_cmp++; if (a.mem_r_en_output !== 1'b0) begin n_bad++; $display("FAIL nomem_rd cyc %0d got %b exp 0", c, a.mem_r_en_output); end
      n_cmp++; if (a.dest_output !== 4'd5) begin n_bad++; $display("FAIL nomem_dest got %h exp 5", a.dest_output); end
      n_cmp++; if (a.alu_res_output !== 32'h0000_1234) begin n_bad++; $display("FAIL nomem_alu got %h exp 1234", a.alu_res_output); end
      n_cmp++; if (a.data_mem_output !== 32'h0) begin n_bad++; $display("FAIL nomem_data got %h exp 0", a.data_mem_output); end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic check_load(input string name, input int stalls, input int exp_stalls,
                            input int wbp, input bit to);
    logic [31:0] e, g;
    n_cmp++; if (to) begin n_bad++; $display("FAIL %s_timeout got no ready exp ready", name); end
    n_cmp++; if (stalls != exp_stalls) begin n_bad++; $display("FAIL %s_stalls got %0d exp %0d", name, stalls, exp_stalls); end
    n_cmp++; if (wbp != 1) begin n_bad++; $display("FAIL %s_wb_pulses got %0d exp 1", name, wbp); end
    e = exp_q.pop_front();
    n_cmp++;
    if (got_q.size() == 0) begin n_bad++; $display("FAIL %s_data got none exp %h", name, e); end
    else begin
      g = got_q.pop_front();
      if (g !== e) begin n_bad++; $display("FAIL %s_data got %h exp %h", name, g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int s, w; bit to;
    run_op(0, 1, 32'd1024, 32'hDEADBEEF, s, w, to);
    n_cmp++; if (to || s != ST_STALL) begin n_bad++; $display("FAIL b2b_store_stalls got %0d exp %0d", s, ST_STALL); end
    exp_q.push_back(32'hDEADBEEF);
    run_op(1, 0, 32'd1024, 32'h0, s, w, to);
    check_load("b2b_load", s, LD_AFTER_ST, w, to);
  endtask

  task automatic test_wrap();
    int s, w; bit to;
    run_op(0, 1, 32'd1024, 32'h12345678, s, w, to);
    n_cmp++; if (to || s != ST_STALL) begin n_bad++; $display("FAIL wrap_store_stalls got %0d exp %0d", s, ST_STALL); end
    exp_q.push_back(32'h12345678);
    run_op(1, 0, 32'd1280, 32'h0, s, w, to);
    check_load("wrap_1280", s, LD_AFTER_ST, w, to);
    exp_q.push_back(32'h12345678);
    run_op(1, 0, 32'd1027, 32'h0, s, w, to);
    check_load("wrap_1027", s, 5, w, to);
  endtask

  task automatic test_both_bits();
    int s, w; bit to;
    run_op(1, 1, 32'd1036, 32'hCAFEF00D, s, w, to);
    n_cmp++; if (to || s != ST_STALL) begin n_bad++; $display("FAIL both_stalls got %0d exp %0d", s, ST_STALL); end
    exp_q.push_back(32'hCAFEF00D);
    run_op(1, 0, 32'd1036, 32'h0, s, w, to);
    check_load("both_load", s, LD_AFTER_ST, w, to);
  endtask

  task automatic test_reset_abort();
    int s, w; bit to;
    run_op(0, 1, 32'd1032, 32'h11111111, s, w, to);
    repeat (8) @(posedge clk);
    #1;
    a.mem_w_en_input = 1; a.alu_res_input = 32'd1032; a.val_rm_i = 32'h55;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0; idle_inputs();
    @(negedge clk);
    n_cmp++; if (a.ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got %b exp 1", a.ready); end
    @(posedge clk); #1;
    exp_q.push_back(32'h11111111);
    run_op(1, 0, 32'd1032, 32'h0, s, w, to);
    check_load("abort_load", s, 5, w, to);
  endtask

  task automatic test_ws1();
    int s; bit done;
    b.mem_r_en_input = 1; b.wb_en_input = 1; b.alu_res_input = 32'd1024;
    s = 0; done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b.ready) done = 1; else s++;
      @(posedge clk); #1;
      if (done) break;
    end
    idle_inputs();
    n_cmp++; if (!done || s != 1) begin n_bad++; $display("FAIL ws1_stalls got %0d done %b exp 1", s, done); end
  endtask

`ifdef MEM_WRITE_BUFFER_EN
  task automatic test_write_buffer();
    int s, w; bit to;
    run_op(0, 1, 32'd1040, 32'h000000A5, s, w, to);
    n_cmp++; if (to || s != 0) begin n_bad++; $display("FAIL wbuf_store_stalls got %0d exp 0", s); end
    exp_q.push_back(32'h000000A5);
    run_op(1, 0, 32'd1040, 32'h0, s, w, to);
    check_load("wbuf_load", s, 10, w, to);
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_wrap();
    test_both_bits();
    test_reset_abort();
    test_ws1();
`ifdef MEM_WRITE_BUFFER_EN
    test_write_buffer();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_wait_unit.md
# mem_wait_unit

Parametrised memory stage for the five-stage ARM pipeline, sitting between the EXE/MEM and MEM/WB registers in place of the single-cycle memory stage. It owns a word-addressed data array that is modelled as a slow SRAM with a configurable number of wait states. It drives a `ready` signal that the top level ORs into the pipeline freeze. While an access is in flight, it injects bubbles toward write-back.

## Interface
Parameters:
- `DEPTH`, 64: data array size in 32-bit words; power of two, ≥ 2.
- `WAIT_STATES`, 5: stall cycles per access; legal range 1–15.
- `BASE_ADDR`, 1024: byte address mapped to word 0.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mem_r_en_input` input 1: load request from EXE/MEM.
- `mem_w_en_input` input 1: store request from EXE/MEM.
- `wb_en_input` input 1: write-back enable from EXE/MEM.
- `dest_input` input 4: destination register.
- `alu_res_input` input 32: ALU result, used as the byte address on loads and stores.
- `val_rm_i` input 32: store data.
- `ready` output 1: 0 means the pipeline must freeze (IF, IF/ID, ID/EXE, EXE/MEM held).
- `wb_en_output` output 1: equals `wb_en_input & ready`.
- `mem_r_en_output` output 1: equals `mem_r_en_input & ready`.
- `dest_output` output 4: pass-through of `dest_input`.
- `alu_res_output` output 32: pass-through of `alu_res_input`.
- `data_mem_output` output 32: registered load data.

## Operation
- Request: `req = mem_r_en_input | mem_w_en_input`. Both bits set at once is treated as a store.
- Index: `idx = ((alu_res_input - BASE_ADDR) >> 2) mod DEPTH`.
  - Address bits [1:0] are ignored.
  - Out-of-range addresses wrap on the low index bits; no error is raised.
- FSM states: IDLE, WAIT, DONE. A 4-bit counter `cnt` runs alongside.
  - IDLE with `req` = 0: stay in IDLE; `ready` = 1.
  - IDLE with `req` = 1: `ready` = 0; `cnt` ← 1; go to DONE if `WAIT_STATES` = 1, else go to WAIT.
  - WAIT: `ready` = 0; `cnt` increments; go to DONE on the edge where `cnt` = `WAIT_STATES - 1`.
  - Load read: on the edge that enters DONE, `data_mem_output` ← `array[idx]`.
  - DONE: `ready` = 1. On the DONE edge:
    - a store writes `val_rm_i` to `array[idx]`;
    - the FSM returns to IDLE;
    - the pipeline advances.
- Non-memory instructions in IDLE pass through with `ready` = 1 and no stall.
- Gating of `wb_en_output` and `mem_r_en_output` by `ready` means the un-frozen MEM/WB register captures bubbles during a stall. Write-back therefore happens exactly once per instruction.
- Inputs are stable while `ready` = 0, because EXE/MEM is frozen. The block does not re-latch its inputs.

## Timing
- Reset values:
  - state IDLE, `cnt` = 0, `data_mem_output` = 0;
  - `ready` = 1 unless `req` = 1;
  - gated outputs follow their inputs combinationally;
  - array contents are not cleared.
- Access latency: the request is presented in cycle 0.
  - `ready` = 0 in cycles 0 through `WAIT_STATES - 1`.
  - `ready` = 1 in cycle `WAIT_STATES`.
  - Total `WAIT_STATES + 1` cycles per load or store.
- Back-to-back memory instructions: the second one starts in IDLE in the cycle after DONE. No extra gap is inserted.
- Reset during WAIT or DONE: the access is abandoned and a pending store is not committed. `ready` returns to the combinational IDLE value in the next cycle.
- `ready`, `wb_en_output` and `mem_r_en_output` are combinational from state and inputs. `data_mem_output` is registered.

## Configuration
- `MEM_WRITE_BUFFER_EN` defined: a one-entry posted write buffer (address, data, busy flag, drain counter) is compiled in.
  - Store in IDLE with the buffer empty: accepted with `ready` = 1 in cycle 0. The buffer latches the entry and drains it to the array after `WAIT_STATES + 1` cycles, in the background.
  - Any load or store while the buffer is busy: `ready` = 0 until the drain edge. The request then starts the normal FSM from IDLE.
  - Non-memory instructions never stall on the buffer.
  - Reset empties the buffer without committing it.
- `MEM_WRITE_BUFFER_EN` undefined: the buffer is not compiled in; stores take the full FSM path described above.

## Test plan
- Reset, then a non-memory instruction with `wb_en_input` = 1 → `ready` = 1 in every cycle, `wb_en_output` = 1, `data_mem_output` = 0.
- Store 0xDEADBEEF to 1024, then load from 1024, back-to-back, with `WAIT_STATES` = 5 → `ready` low for 5 cycles per instruction. In the load's DONE cycle, `data_mem_output` = 0xDEADBEEF and `wb_en_output` = 1 for exactly one cycle.
- Load from 1024 + 4·64 = 1280 after storing 0x12345678 at 1024 → the address wraps and 0x12345678 is returned. A load from 1027 also returns 0x12345678.
- Assert `rst` in cycle 3 of a store of 0x55 to 1032 → `ready` = 1 afterwards, and a later load from 1032 returns the old value, not 0x55.
- `WAIT_STATES` = 1: a load → `ready` = 0 for exactly 1 cycle; 2 cycles total.
- With `MEM_WRITE_BUFFER_EN` defined: store 0xA5 to 1040, then immediately load from 1040 → the store shows `ready` = 1 with no stall. The load stalls until the drain, then takes 6 more cycles and returns 0xA5.
